// File: rtl/snn_pkg.sv
// snn_pkg: definitions shared by the spiking-network blocks (lif_neuron,
// lif_syn_sum, stdp_synapse).
//   - lif_state_e       : neuron FSM states
//   - SNN_WEIGHT_WIDTH  : common synaptic weight width, kept equal to the
//                         width stdp_synapse produces
//   - sat_add()         : unsigned add clamped to an all-ones value of a
//                         given width
package snn_pkg;

  localparam int SNN_WEIGHT_WIDTH = 8;

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } lif_state_e;

  // Unsigned a + b, clamped to 2^width-1. The internal sum carries one extra
  // bit so operands up to 64 bits never wrap before the clamp.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] s;
    logic [64:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << width) - 65'd1;
    return (s > lim) ? lim[63:0] : s[63:0];
  endfunction

endpackage

// File: rtl/lif_syn_sum.sv
// lif_syn_sum: combinational masked adder. Adds weight i to the sum only
// when in_spike[i] is set.
//   in_spike  in  NUM_INPUTS               presynaptic spikes
//   weights   in  NUM_INPUTS*WEIGHT_WIDTH  flat bus, input i at [i*W +: W]
//   syn_sum   out SUM_WIDTH                sum of the selected weights
module lif_syn_sum #(
  parameter int NUM_INPUTS   = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int SUM_WIDTH    = WEIGHT_WIDTH + $clog2(NUM_INPUTS) + 1
) (
  input  logic [NUM_INPUTS-1:0]              in_spike,
  input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] weights,
  output logic [SUM_WIDTH-1:0]               syn_sum
);

  logic [SUM_WIDTH-1:0] masked [NUM_INPUTS];

  // Zero-extend each weight to the full sum width and gate it by its spike.
  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_mask
      assign masked[gi] = in_spike[gi]
          ? SUM_WIDTH'(weights[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH])
          : '0;
    end
  endgenerate

  always_comb begin
    syn_sum = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      syn_sum = syn_sum + masked[i];
    end
  end

endmodule

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron.
// Each enabled cycle in INTEGRATE it leaks v_mem by v_mem>>LEAK_SHIFT, adds
// the weighted sum of active inputs (saturating), and fires when the result
// reaches V_THRESH. A fire resets v_mem to V_REST and, if REFRAC_CYCLES>0,
// starts a refractory period of REFRAC_CYCLES enabled cycles during which
// inputs are ignored.
//   clk          in   clock, all logic on posedge
//   rst          in   synchronous active-high reset
//   enable       in   neuron advances only when high
//   in_spike     in   presynaptic spikes, one bit per input
//   weights      in   flat weight bus, input i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   v_mem        out  registered membrane potential
//   post_spike   out  one-cycle registered fire pulse
//   refractory   out  high while in REFRACTORY
//   spike_count  out  fires since reset, wraps
module lif_neuron
  import snn_pkg::*;
#(
  parameter int                 NUM_INPUTS    = 4,
  parameter int                 WEIGHT_WIDTH  = SNN_WEIGHT_WIDTH,
  parameter int                 V_WIDTH       = 16,
  parameter logic [V_WIDTH-1:0] V_THRESH      = 16'd1000,
  parameter logic [V_WIDTH-1:0] V_REST        = 16'd0,
  parameter int                 LEAK_SHIFT    = 4,
  parameter int                 REFRAC_CYCLES = 5,
  parameter int                 CNT_WIDTH     = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [NUM_INPUTS-1:0]              in_spike,
  input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] weights,
  output logic [V_WIDTH-1:0]                 v_mem,
  output logic                               post_spike,
  output logic                               refractory,
  output logic [CNT_WIDTH-1:0]               spike_count
);

  localparam int SUM_WIDTH = WEIGHT_WIDTH + $clog2(NUM_INPUTS) + 1;
  localparam int RC_WIDTH  = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;

  lif_state_e           state_q, state_d;
  logic [V_WIDTH-1:0]   v_q, v_d;
  logic                 spike_q, spike_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [RC_WIDTH-1:0]  rcnt_q, rcnt_d;

  logic [SUM_WIDTH-1:0] syn_sum;
  logic [V_WIDTH-1:0]   v_leaked;
  logic [V_WIDTH-1:0]   v_next;
  logic                 fire;

  lif_syn_sum #(
    .NUM_INPUTS  (NUM_INPUTS),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .SUM_WIDTH   (SUM_WIDTH)
  ) u_syn_sum (
    .in_spike(in_spike),
    .weights (weights),
    .syn_sum (syn_sum)
  );

  // Leak never underflows because v>>LEAK_SHIFT <= v. The add is carried out
  // wide enough for both operands so a large synaptic sum cannot wrap into a
  // small value before it is clamped to the V_WIDTH maximum.
  assign v_leaked = v_q - (v_q >> LEAK_SHIFT);
  assign v_next   = V_WIDTH'(sat_add(64'(v_leaked), 64'(syn_sum), V_WIDTH));
  assign fire     = (v_next >= V_THRESH);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    spike_d = 1'b0;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    if (enable) begin
      unique case (state_q)
        INTEGRATE: begin
          if (fire) begin
            v_d     = V_REST;
            spike_d = 1'b1;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            if (REFRAC_CYCLES > 0) begin
              state_d = REFRACTORY;
              rcnt_d  = RC_WIDTH'(REFRAC_CYCLES);
            end
          end else begin
            v_d = v_next;
          end
        end
        REFRACTORY: begin
          // Inputs are ignored; the count reaching 1 marks the last ignored
          // edge, so the following edge integrates again.
          v_d    = V_REST;
          rcnt_d = rcnt_q - RC_WIDTH'(1);
          if (rcnt_q == RC_WIDTH'(1)) begin
            state_d = INTEGRATE;
          end
        end
        default: state_d = INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INTEGRATE;
      v_q     <= V_REST;
      spike_q <= 1'b0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign v_mem       = v_q;
  assign post_spike  = spike_q;
  assign refractory  = (state_q == REFRACTORY);
  assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed testbench for lif_neuron. Three instances share clk/rst:
//   dut_a: default parameters
//   dut_s: 16-bit weights, V_THRESH=16'hFFFF (saturation)
//   dut_w: CNT_WIDTH=2, REFRAC_CYCLES=0, V_THRESH=200 (counter wrap)
module tb_lif_neuron;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        en_a;
  logic [3:0]  in_a;
  logic [31:0] w_a;
  logic [15:0] v_a;
  logic        ps_a, rf_a;
  logic [15:0] cnt_a;

  logic        en_s;
  logic [3:0]  in_s;
  logic [63:0] w_s;
  logic [15:0] v_s;
  logic        ps_s, rf_s;
  logic [15:0] cnt_s;

  logic        en_w;
  logic [3:0]  in_w;
  logic [31:0] w_w;
  logic [15:0] v_w;
  logic        ps_w, rf_w;
  logic [1:0]  cnt_w;

  int n_checks = 0;
  int n_fail   = 0;

  lif_neuron dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .in_spike(in_a), .weights(w_a),
    .v_mem(v_a), .post_spike(ps_a), .refractory(rf_a), .spike_count(cnt_a)
  );

  lif_neuron #(
    .WEIGHT_WIDTH(16), .V_THRESH(16'hFFFF)
  ) dut_s (
    .clk(clk), .rst(rst), .enable(en_s), .in_spike(in_s), .weights(w_s),
    .v_mem(v_s), .post_spike(ps_s), .refractory(rf_s), .spike_count(cnt_s)
  );

  lif_neuron #(
    .CNT_WIDTH(2), .REFRAC_CYCLES(0), .V_THRESH(16'd200)
  ) dut_w (
    .clk(clk), .rst(rst), .enable(en_w), .in_spike(in_w), .weights(w_w),
    .v_mem(v_w), .post_spike(ps_w), .refractory(rf_w), .spike_count(cnt_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int v, input int ps, input int rf, input int cnt);
    chk({tag, ".v_mem"}, 32'(v_a), 32'(v));
    chk({tag, ".post_spike"}, 32'(ps_a), 32'(ps));
    chk({tag, ".refractory"}, 32'(rf_a), 32'(rf));
    chk({tag, ".spike_count"}, 32'(cnt_a), 32'(cnt));
    $display("step %-12s v_mem=%0d post_spike=%0d refractory=%0d spike_count=%0d",
             tag, v_a, ps_a, rf_a, cnt_a);
  endtask

  initial begin
    rst  = 1'b1;
    en_a = 1'b0; in_a = '0; w_a = '0;
    en_s = 1'b0; in_s = '0; w_s = '0;
    en_w = 1'b0; in_w = '0; w_w = '0;
    step();
    step();
    chk_a("reset", 0, 0, 0, 0);
    chk("reset_s.v_mem", 32'(v_s), 32'd0);
    chk("reset_w.spike_count", 32'(cnt_w), 32'd0);

    // Single input, constant drive: 255, 495, 720, 930
    rst  = 1'b0;
    en_a = 1'b1;
    w_a  = {4{8'd255}};
    in_a = 4'b0001;
    step(); chk_a("int1", 255, 0, 0, 0);
    step(); chk_a("int2", 495, 0, 0, 0);
    step(); chk_a("int3", 720, 0, 0, 0);
    step(); chk_a("int4", 930, 0, 0, 0);

    // Leak only: 872, 818, 767
    in_a = 4'b0000;
    step(); chk_a("leak1", 872, 0, 0, 0);
    step(); chk_a("leak2", 818, 0, 0, 0);
    step(); chk_a("leak3", 767, 0, 0, 0);

    // Resume drive: 767-47+255=975, then 975-60+255=1170 fires
    in_a = 4'b0001;
    step(); chk_a("int5", 975, 0, 0, 0);
    step(); chk_a("fire1", 0, 1, 1, 1);

    // Refractory masking with every input active at 255
    in_a = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step(); chk_a("refr", 0, 0, 1, 1);
    end
    step(); chk_a("refr_last", 0, 0, 0, 1);
    step(); chk_a("fire2", 0, 1, 1, 2);   // v_next=1020 >= 1000

    // Stall mid-refractory: one count consumed, then 3 frozen cycles
    step(); chk_a("refr_a", 0, 0, 1, 2);
    en_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); chk_a("stall", 0, 0, 1, 2);
    end
    en_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); chk_a("refr_b", 0, 0, 1, 2);
    end
    step(); chk_a("refr_done", 0, 0, 0, 2);

    // Reach v_mem=500 (255+245) then reset during INTEGRATE
    w_a  = {8'd0, 8'd0, 8'd245, 8'd255};
    in_a = 4'b0011;
    step(); chk_a("v500", 500, 0, 0, 2);
    rst = 1'b1;
    step(); chk_a("rst_mid", 0, 0, 0, 0);
    rst  = 1'b0;
    en_a = 1'b0;
    in_a = '0;

    // Saturation: reach 16'hFF00, then a 4x16'hFFFF sum clamps to FFFF and fires
    en_s = 1'b1;
    w_s  = {16'h0, 16'h0, 16'h0, 16'hFF00};
    in_s = 4'b0001;
    step();
    chk("sat_pre.v_mem", 32'(v_s), 32'h0000_FF00);
    chk("sat_pre.post_spike", 32'(ps_s), 32'd0);
    $display("step sat_pre      v_mem=%0d post_spike=%0d", v_s, ps_s);
    w_s  = {4{16'hFFFF}};
    in_s = 4'b1111;
    step();
    chk("sat_fire.post_spike", 32'(ps_s), 32'd1);
    chk("sat_fire.v_mem", 32'(v_s), 32'd0);
    chk("sat_fire.spike_count", 32'(cnt_s), 32'd1);
    chk("sat_fire.refractory", 32'(rf_s), 32'd1);
    $display("step sat_fire     v_mem=%0d post_spike=%0d spike_count=%0d", v_s, ps_s, cnt_s);
    en_s = 1'b0;

    // Counter wrap: fires on every edge, count 1,2,3,0
    en_w = 1'b1;
    w_w  = {24'd0, 8'd255};
    in_w = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("wrap.spike_count", 32'(cnt_w), 32'(k % 4));
      chk("wrap.post_spike", 32'(ps_w), 32'd1);
      chk("wrap.v_mem", 32'(v_w), 32'd0);
      chk("wrap.refractory", 32'(rf_w), 32'd0);
      $display("step wrap%0d       spike_count=%0d post_spike=%0d", k, cnt_w, ps_w);
    end
    en_w = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
